// File: rtl/alu_8bit_if.sv
// alu_8bit_if -- operand/opcode/result bundle for alu_8bit.
//   a, b  : 8-bit unsigned operands (master -> slave)
//   s     : 4-bit opcode select      (master -> slave)
//   en    : operation enable         (master -> slave)
//   y     : 16-bit registered result (slave -> master)
//   carry : registered carry/borrow/shifted-out bit (slave -> master)
//   zero  : registered y==0 flag     (slave -> master)
interface alu_8bit_if;
    logic [7:0]  a;
    logic [7:0]  b;
    logic [3:0]  s;
    logic        en;
    logic [15:0] y;
    logic        carry;
    logic        zero;

    modport master (output a, b, s, en, input  y, carry, zero);
    modport slave  (input  a, b, s, en, output y, carry, zero);
endinterface

// File: rtl/alu_8bit.sv
// alu_8bit -- single-cycle registered 8-bit ALU with 16-bit result.
//   clk   : rising-edge clock
//   rst_n : synchronous active-low reset (y=0, carry=0, zero=1)
//   bus   : alu_8bit_if.slave -- a, b, s, en in; y, carry, zero out
// Result and flags load one edge after inputs when en=1 and hold when en=0.
module alu_8bit (
    input  logic       clk,
    input  logic       rst_n,
    alu_8bit_if.slave  bus
);
    localparam logic [3:0] OP_CLR  = 4'd0,  OP_ADD  = 4'd1,  OP_SUB  = 4'd2,
                           OP_MUL  = 4'd3,  OP_AND  = 4'd4,  OP_OR   = 4'd5,
                           OP_XOR  = 4'd6,  OP_NAND = 4'd7,  OP_NOR  = 4'd8,
                           OP_XNOR = 4'd9,  OP_NOT  = 4'd10, OP_SHL  = 4'd11,
                           OP_SHR  = 4'd12, OP_ROL  = 4'd13, OP_ROR  = 4'd14,
                           OP_CMP  = 4'd15;

    logic [15:0] y_q, y_d;
    logic        carry_q, carry_d;
    logic        zero_q, zero_d;

    logic [15:0] res;
    logic        res_c;
    logic [8:0]  sum9;
    logic [7:0]  diff;
    logic [7:0]  a, b;

    assign a    = bus.a;
    assign b    = bus.b;
    assign sum9 = {1'b0, a} + {1'b0, b};
    assign diff = a - b;

    always_comb begin
        res   = 16'h0000;
        res_c = 1'b0;
        case (bus.s)
            OP_CLR:  res = 16'h0000;
            OP_ADD:  begin res = {7'b0, sum9};  res_c = sum9[8]; end
            OP_SUB:  begin res = {8'h00, diff}; res_c = (a < b);  end
            OP_MUL:  res = {8'h00, a} * {8'h00, b};
            OP_AND:  res = {8'h00, a & b};
            OP_OR:   res = {8'h00, a | b};
            OP_XOR:  res = {8'h00, a ^ b};
            OP_NAND: res = {8'h00, ~(a & b)};
            OP_NOR:  res = {8'h00, ~(a | b)};
            OP_XNOR: res = {8'h00, ~(a ^ b)};
            OP_NOT:  res = {8'h00, ~a};
            OP_SHL:  begin res = {8'h00, a[6:0], 1'b0}; res_c = a[7]; end
            OP_SHR:  begin res = {8'h00, 1'b0, a[7:1]}; res_c = a[0]; end
            OP_ROL:  begin res = {8'h00, a[6:0], a[7]}; res_c = a[7]; end
            OP_ROR:  begin res = {8'h00, a[0], a[7:1]}; res_c = a[0]; end
            OP_CMP:  res = {13'b0, (a > b), (a == b), (a < b)};
            default: res = 16'h0000;
        endcase
    end

    // zero is derived from the value being loaded so it never lags y.
    always_comb begin
        y_d     = y_q;
        carry_d = carry_q;
        zero_d  = zero_q;
        if (bus.en) begin
            y_d     = res;
            carry_d = res_c;
            zero_d  = (res == 16'h0000);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            y_q     <= 16'h0000;
            carry_q <= 1'b0;
            zero_q  <= 1'b1;
        end else begin
            y_q     <= y_d;
            carry_q <= carry_d;
            zero_q  <= zero_d;
        end
    end

    assign bus.y     = y_q;
    assign bus.carry = carry_q;
    assign bus.zero  = zero_q;
endmodule

// File: tb/tb_alu_8bit.sv
// tb_alu_8bit -- self-checking bench for alu_8bit. Stimulus pushes the
// model's expected outputs into a scoreboard queue; each test pops and
// compares after the edge that should produce them.
module tb_alu_8bit;
    typedef struct {
        logic [15:0] y;
        logic        c;
        logic        z;
    } exp_t;

    logic clk;
    logic rst_n;
    alu_8bit_if bus ();

    alu_8bit dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    exp_t sb[$];
    exp_t mdl;
    int   n_chk  = 0;
    int   n_fail = 0;

    // Reference model written with integer arithmetic.
    function automatic exp_t calc(input logic [7:0] ia, input logic [7:0] ib,
                                  input logic [3:0] is);
        exp_t r;
        int ai, bi, t;
        ai = int'(ia);
        bi = int'(ib);
        t  = 0;
        r.c = 1'b0;
        case (int'(is))
            0:  t = 0;
            1:  begin t = ai + bi; r.c = (t >= 256); end
            2:  begin t = (ai - bi + 256) % 256; r.c = (ai < bi); end
            3:  t = ai * bi;
            4:  t = ai & bi;
            5:  t = ai | bi;
            6:  t = ai ^ bi;
            7:  t = 255 - (ai & bi);
            8:  t = 255 - (ai | bi);
            9:  t = 255 - (ai ^ bi);
            10: t = 255 - ai;
            11: begin t = (ai * 2) % 256; r.c = (ai >= 128); end
            12: begin t = ai / 2; r.c = (ai % 2 == 1); end
            13: begin t = (ai * 2) % 256 + ai / 128; r.c = (ai >= 128); end
            14: begin t = ai / 2 + (ai % 2) * 128; r.c = (ai % 2 == 1); end
            default: t = (ai > bi) ? 4 : ((ai == bi) ? 2 : 1);
        endcase
        r.y = 16'(t);
        r.z = (t == 0);
        return r;
    endfunction

    task automatic apply(input logic [7:0] ia, input logic [7:0] ib,
                         input logic [3:0] is, input logic ien, input logic irst);
        @(negedge clk);
        bus.a  = ia;
        bus.b  = ib;
        bus.s  = is;
        bus.en = ien;
        rst_n  = ~irst;
        if (irst)     mdl = '{16'h0000, 1'b0, 1'b1};
        else if (ien) mdl = calc(ia, ib, is);
        sb.push_back(mdl);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        exp_t e;
        apply(8'h12, 8'h34, 4'd1, 1'b1, 1'b1);
        apply(8'h12, 8'h34, 4'd3, 1'b0, 1'b1);
        e = sb.pop_front();
        e = sb.pop_front();
        n_chk++;
        if (bus.y !== 16'h0000 || bus.carry !== 1'b0 || bus.zero !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_state: got y=%h c=%b z=%b need y=0000 c=0 z=1",
                     bus.y, bus.carry, bus.zero);
        end
        // Released with en=0: reset values must persist.
        for (int i = 0; i < 3; i++) begin
            apply(8'hFF, 8'h01, 4'(i + 1), 1'b0, 1'b0);
            e = sb.pop_front();
            n_chk++;
            if (bus.y !== e.y || bus.carry !== e.c || bus.zero !== e.z) begin
                n_fail++;
                $display("FAIL reset_hold[%0d]: got y=%h c=%b z=%b need y=%h c=%b z=%b",
                         i, bus.y, bus.carry, bus.zero, e.y, e.c, e.z);
            end
        end
    endtask

    task automatic test_directed;
        exp_t e;
        logic [7:0] va[8] = '{8'hEE, 8'hEE, 8'hEE, 8'hEE, 8'hEE, 8'hEE, 8'h10, 8'h20};
        logic [7:0] vb[8] = '{8'hEE, 8'hEE, 8'hEE, 8'h00, 8'h00, 8'hEE, 8'h20, 8'h10};
        logic [3:0] vs[8] = '{4'd1, 4'd2, 4'd3, 4'd11, 4'd14, 4'd15, 4'd15, 4'd15};
        logic [15:0] vy[8] = '{16'h01DC, 16'h0000, 16'hDD44, 16'h00DC, 16'h0077,
                               16'h0002, 16'h0001, 16'h0004};
        logic vc[8] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        logic vz[8] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        for (int i = 0; i < 8; i++) begin
            apply(va[i], vb[i], vs[i], 1'b1, 1'b0);
            e = sb.pop_front();
            n_chk++;
            if (bus.y !== vy[i] || bus.carry !== vc[i] || bus.zero !== vz[i]) begin
                n_fail++;
                $display("FAIL directed[%0d] s=%0d: got y=%h c=%b z=%b need y=%h c=%b z=%b",
                         i, vs[i], bus.y, bus.carry, bus.zero, vy[i], vc[i], vz[i]);
            end
        end
    endtask

    // Every opcode back to back, with boundary and random operands.
    task automatic test_all_ops;
        exp_t e;
        logic [7:0] ra, rb;
        for (int k = 0; k < 6; k++) begin
            for (int op = 0; op < 16; op++) begin
                case (k)
                    0: begin ra = 8'h00; rb = 8'h00; end
                    1: begin ra = 8'hFF; rb = 8'hFF; end
                    2: begin ra = 8'h00; rb = 8'hFF; end
                    default: begin
                        ra = 8'($urandom_range(0, 255));
                        rb = 8'($urandom_range(0, 255));
                    end
                endcase
                apply(ra, rb, 4'(op), 1'b1, 1'b0);
                e = sb.pop_front();
                n_chk++;
                if (bus.y !== e.y || bus.carry !== e.c || bus.zero !== e.z) begin
                    n_fail++;
                    $display("FAIL op s=%0d a=%h b=%h: got y=%h c=%b z=%b need y=%h c=%b z=%b",
                             op, ra, rb, bus.y, bus.carry, bus.zero, e.y, e.c, e.z);
                end
            end
        end
    endtask

    task automatic test_hold;
        exp_t e;
        apply(8'h80, 8'h81, 4'd1, 1'b1, 1'b0);
        e = sb.pop_front();
        n_chk++;
        if (bus.y !== 16'h0101 || bus.carry !== 1'b1 || bus.zero !== 1'b0) begin
            n_fail++;
            $display("FAIL hold_add: got y=%h c=%b z=%b need y=0101 c=1 z=0",
                     bus.y, bus.carry, bus.zero);
        end
        for (int op = 0; op < 16; op++) begin
            apply(8'(op * 17), 8'h5A, 4'(op), 1'b0, 1'b0);
            e = sb.pop_front();
            n_chk++;
            if (bus.y !== e.y || bus.carry !== e.c || bus.zero !== e.z) begin
                n_fail++;
                $display("FAIL hold s=%0d: got y=%h c=%b z=%b need y=%h c=%b z=%b",
                         op, bus.y, bus.carry, bus.zero, e.y, e.c, e.z);
            end
        end
        apply(8'h05, 8'h05, 4'd2, 1'b1, 1'b0);
        e = sb.pop_front();
        n_chk++;
        if (bus.y !== 16'h0000 || bus.carry !== 1'b0 || bus.zero !== 1'b1) begin
            n_fail++;
            $display("FAIL hold_release: got y=%h c=%b z=%b need y=0000 c=0 z=1",
                     bus.y, bus.carry, bus.zero);
        end
    endtask

    task automatic test_reset_mid;
        exp_t e;
        apply(8'hEE, 8'hEE, 4'd3, 1'b1, 1'b0);
        e = sb.pop_front();
        apply(8'hEE, 8'hEE, 4'd3, 1'b1, 1'b1);
        e = sb.pop_front();
        n_chk++;
        if (bus.y !== 16'h0000 || bus.carry !== 1'b0 || bus.zero !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_mid: got y=%h c=%b z=%b need y=0000 c=0 z=1",
                     bus.y, bus.carry, bus.zero);
        end
        apply(8'h0F, 8'h11, 4'd3, 1'b1, 1'b0);
        e = sb.pop_front();
        n_chk++;
        if (bus.y !== e.y || bus.carry !== e.c || bus.zero !== e.z) begin
            n_fail++;
            $display("FAIL reset_mid_resume: got y=%h c=%b z=%b need y=%h c=%b z=%b",
                     bus.y, bus.carry, bus.zero, e.y, e.c, e.z);
        end
    endtask

    initial begin
        rst_n  = 1'b0;
        bus.a  = 8'h00;
        bus.b  = 8'h00;
        bus.s  = 4'd0;
        bus.en = 1'b0;
        mdl    = '{16'h0000, 1'b0, 1'b1};
        test_reset();
        test_directed();
        test_all_ops();
        test_hold();
        test_reset_mid();
        n_chk++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d entries left need 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
